// File: rtl/sb_1237_uart_pkg.sv
// Shared encodings and ASCII constants for the host-to-bot UART command receiver.
package sb_1237_uart_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_NODE  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FRAMING  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_SYNTAX   = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_COLLECT,
    P_DISCARD
  } parse_state_t;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_O    = 8'h4F;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_P    = 8'h50;

  localparam int MAX_NODE = 25;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/sb_1237_uart_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, baud counter and bit FSM.
// Emits the received byte with a valid pulse, or a framing error pulse on a low stop bit.
module sb_1237_uart_byte_rx
  import sb_1237_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic sync1_q, sync2_q, rx_prev_q;
  rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic brk_q, brk_d;
  logic valid_d, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // brk_q lets a line held low restart a frame without a new falling edge,
  // so a break keeps reporting one framing error per character time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q && (rx_prev_q || brk_q)) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            brk_d   = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
      if (valid_d) begin
        byte_data <= shift_q;
      end
    end
  end

endmodule

// File: rtl/sb_1237_uart_cmd_rx.sv
// Host command receiver: frames '#'-terminated messages from the byte receiver
// and decodes GO-, STOP- and Ndd- into one-cycle command pulses.
module sb_1237_uart_cmd_rx
  import sb_1237_uart_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115200,
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [4:0] cmd_arg,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic frame_err;

  sb_1237_uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(rx_byte_valid),
    .frame_err (frame_err)
  );

  parse_state_t pstate_q, pstate_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0] buf_q [MAX_LEN];
  logic wr_en;
  logic cmd_fire, perr_fire;
  err_code_t perr_kind;

  logic dec_ok;
  cmd_op_t dec_op;
  logic [4:0] dec_arg;
  logic [7:0] node_val;

  logic cmd_valid_q, perr_q;
  cmd_op_t cmd_op_q;
  logic [4:0] cmd_arg_q;
  err_code_t err_code_q;

  always_comb begin
    dec_ok   = 1'b0;
    dec_op   = OP_NONE;
    dec_arg  = '0;
    node_val = (buf_q[1] - CH_0) * 8'd10 + (buf_q[2] - CH_0);
    if (count_q == CNT_W'(3) && buf_q[0] == CH_G && buf_q[1] == CH_O &&
        buf_q[2] == CH_DASH) begin
      dec_ok = 1'b1;
      dec_op = OP_START;
    end else if (count_q == CNT_W'(5) && buf_q[0] == CH_S && buf_q[1] == CH_T &&
                 buf_q[2] == CH_O && buf_q[3] == CH_P && buf_q[4] == CH_DASH) begin
      dec_ok = 1'b1;
      dec_op = OP_STOP;
    end else if (count_q == CNT_W'(4) && buf_q[0] == CH_N && is_digit(buf_q[1]) &&
                 is_digit(buf_q[2]) && buf_q[3] == CH_DASH &&
                 node_val <= 8'(MAX_NODE)) begin
      dec_ok  = 1'b1;
      dec_op  = OP_NODE;
      dec_arg = node_val[4:0];
    end
  end

  // A framing error abandons any partial message, whatever state we were in.
  always_comb begin
    pstate_d  = pstate_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    cmd_fire  = 1'b0;
    perr_fire = 1'b0;
    perr_kind = ERR_SYNTAX;
    if (frame_err) begin
      pstate_d = P_IDLE;
      count_d  = '0;
    end else if (rx_byte_valid) begin
      case (pstate_q)
        P_IDLE: begin
          if (rx_byte == CH_HASH) begin
            perr_fire = 1'b1;
          end else if (rx_byte != CH_CR && rx_byte != CH_LF) begin
            wr_en    = 1'b1;
            count_d  = CNT_W'(1);
            pstate_d = P_COLLECT;
          end
        end
        P_COLLECT: begin
          if (rx_byte == CH_HASH) begin
            count_d   = '0;
            pstate_d  = P_IDLE;
            cmd_fire  = dec_ok;
            perr_fire = !dec_ok;
          end else if (count_q == CNT_W'(MAX_LEN)) begin
            count_d   = '0;
            pstate_d  = P_DISCARD;
            perr_fire = 1'b1;
            perr_kind = ERR_OVERFLOW;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        P_DISCARD: begin
          if (rx_byte == CH_HASH) begin
            pstate_d = P_IDLE;
          end
        end
        default: pstate_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate_q <= P_IDLE;
      count_q  <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      pstate_q <= pstate_d;
      count_q  <= count_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_en && count_q == CNT_W'(i)) begin
          buf_q[i] <= rx_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NONE;
      cmd_arg_q   <= '0;
      perr_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      cmd_valid_q <= cmd_fire;
      perr_q      <= perr_fire;
      if (cmd_fire) begin
        cmd_op_q  <= dec_op;
        cmd_arg_q <= dec_arg;
      end
      if (frame_err) begin
        err_code_q <= ERR_FRAMING;
      end else if (perr_fire) begin
        err_code_q <= perr_kind;
      end
    end
  end

  // Framing errors are already registered in the byte receiver, so they bypass
  // the parser register to land the cycle after the stop-bit sample.
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_arg   = cmd_arg_q;
  assign err       = perr_q | frame_err;
  assign err_code  = frame_err ? ERR_FRAMING : err_code_q;

endmodule

// File: tb/tb_sb_1237_uart_cmd_rx.sv
// Directed self-checking bench for sb_1237_uart_cmd_rx, run at 16 clocks per bit.
module tb_sb_1237_uart_cmd_rx;

  localparam int BIT = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [4:0] cmd_arg;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int byte_cnt = 0, cmd_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_byte_cyc = 0, cmd_cyc = 0, err_at_byte = 0;
  logic [7:0] last_byte = '0;
  logic [1:0] cmd_op_s = '0, err_code_s = '0;
  logic [4:0] cmd_arg_s = '0;

  int b0, c0, e0;

  sb_1237_uart_cmd_rx #(
    .CLK_HZ (1_600_000),
    .BAUD   (100_000),
    .MAX_LEN(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .err          (err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_byte_valid) begin
      byte_cnt = byte_cnt + 1;
      last_byte_cyc = cyc;
      last_byte = rx_byte;
    end
    if (cmd_valid) begin
      cmd_cnt = cmd_cnt + 1;
      cmd_cyc = cyc;
      cmd_op_s = cmd_op;
      cmd_arg_s = cmd_arg;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      err_code_s = err_code;
      err_at_byte = byte_cnt;
    end
    if (cmd_valid && err) both_cnt = both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      sendByte(s[i], 1'b1);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic snap();
    b0 = byte_cnt;
    c0 = cmd_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rx_byte", {24'd0, rx_byte}, 0);
    checkOutput("reset rx_byte_valid", {31'd0, rx_byte_valid}, 0);
    checkOutput("reset cmd_valid", {31'd0, cmd_valid}, 0);
    checkOutput("reset cmd_op", {30'd0, cmd_op}, 0);
    checkOutput("reset cmd_arg", {27'd0, cmd_arg}, 0);
    checkOutput("reset err", {31'd0, err}, 0);
    checkOutput("reset err_code", {30'd0, err_code}, 0);
    @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    snap();
    applyStimulus("GO-#");
    checkOutput("go bytes", byte_cnt - b0, 4);
    checkOutput("go last byte", {24'd0, last_byte}, 32'h23);
    checkOutput("go cmd count", cmd_cnt - c0, 1);
    checkOutput("go op", {30'd0, cmd_op_s}, 1);
    checkOutput("go arg", {27'd0, cmd_arg_s}, 0);
    checkOutput("go latency", cmd_cyc - last_byte_cyc, 1);
    checkOutput("go err count", err_cnt - e0, 0);

    snap();
    applyStimulus("N19-#");
    checkOutput("n19 cmd count", cmd_cnt - c0, 1);
    checkOutput("n19 op", {30'd0, cmd_op_s}, 3);
    checkOutput("n19 arg", {27'd0, cmd_arg_s}, 19);

    snap();
    applyStimulus("N26-#");
    checkOutput("n26 cmd count", cmd_cnt - c0, 0);
    checkOutput("n26 err count", err_cnt - e0, 1);
    checkOutput("n26 err code", {30'd0, err_code_s}, 3);

    snap();
    sendByte(8'h41, 1'b0);
    repeat (3 * BIT) @(posedge clk);
    checkOutput("frame bytes", byte_cnt - b0, 0);
    checkOutput("frame err count", err_cnt - e0, 1);
    checkOutput("frame err code", {30'd0, err_code_s}, 1);
    #1;
    checkOutput("frame code held", {30'd0, err_code}, 1);
    snap();
    applyStimulus("STOP-#");
    checkOutput("stop cmd count", cmd_cnt - c0, 1);
    checkOutput("stop op", {30'd0, cmd_op_s}, 2);
    checkOutput("stop err count", err_cnt - e0, 0);

    snap();
    applyStimulus("ABCDEFGHIJ#");
    checkOutput("ovf bytes", byte_cnt - b0, 11);
    checkOutput("ovf err count", err_cnt - e0, 1);
    checkOutput("ovf err code", {30'd0, err_code_s}, 2);
    checkOutput("ovf on 9th byte", err_at_byte - b0, 9);
    checkOutput("ovf cmd count", cmd_cnt - c0, 0);
    snap();
    applyStimulus("GO-#");
    checkOutput("post ovf cmd count", cmd_cnt - c0, 1);
    checkOutput("post ovf op", {30'd0, cmd_op_s}, 1);

    snap();
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    checkOutput("glitch bytes", byte_cnt - b0, 0);
    checkOutput("glitch err count", err_cnt - e0, 0);
    sendByte(8'h0D, 1'b1);
    sendByte(8'h0A, 1'b1);
    applyStimulus("N07-#");
    checkOutput("n07 cmd count", cmd_cnt - c0, 1);
    checkOutput("n07 op", {30'd0, cmd_op_s}, 3);
    checkOutput("n07 arg", {27'd0, cmd_arg_s}, 7);
    checkOutput("n07 err count", err_cnt - e0, 0);

    snap();
    applyStimulus("N1");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    applyStimulus("5-#");
    checkOutput("rst cmd count", cmd_cnt - c0, 0);
    checkOutput("rst err count", err_cnt - e0, 1);
    checkOutput("rst err code", {30'd0, err_code_s}, 3);

    checkOutput("cmd and err overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
